// File: rtl/edac_mem_seq.sv
// Sequencer between a CPU byte port and an EDAC wrapper with a 32-bit protected memory.
// Latency from the accept edge: write 3 cycles, clean read 4 cycles, each decode retry adds 3.
// One request in flight; req_ready is high only in IDLE, and a new request may be taken in the rsp_valid cycle.
module edac_mem_seq #(
    parameter int          ADDR_W     = 10,
    parameter logic [31:0] ERROR_CODE = 32'hFFFFFFFF,
    parameter int          MAX_RETRY  = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic [15:0]       err_count,
    output logic              edac_en,
    output logic              edac_read,
    output logic [31:0]       edac_din,
    input  logic [31:0]       edac_dout,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        W_ENC = 3'd1,
        W_MEM = 3'd2,
        R_MEM = 3'd3,
        R_DEC = 3'd4,
        R_CHK = 3'd5
    } state_t;

    // Retry limit narrowed to the counter width (legal range is 0..3).
    localparam logic [1:0] RETRY_LIMIT = MAX_RETRY[1:0];

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic [1:0]        retry_q;
    logic [15:0]       err_cnt_q;
    logic              rsp_valid_q;
    logic [7:0]        rsp_rdata_q;
    logic              rsp_err_q;
    logic              accept;
    logic              dec_fail;
    logic              can_retry;

    assign req_ready = (state_q == IDLE) && !reset;
    assign mem_addr  = addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_cnt_q;
    assign can_retry = retry_q < RETRY_LIMIT;

    // State register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and memory/EDAC controls, decoded only from the registered state.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        dec_fail  = 1'b0;
        edac_en   = 1'b0;
        edac_read = 1'b0;
        edac_din  = 32'h0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;
        case (state_q)
            IDLE: begin
                if (req_valid && !reset) begin
                    accept  = 1'b1;
                    state_d = req_we ? W_ENC : R_MEM;
                end
            end
            W_ENC: begin
                edac_en  = 1'b1;
                edac_din = {24'h0, wdata_q};
                state_d  = W_MEM;
            end
            W_MEM: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = edac_dout;
                state_d   = IDLE;
            end
            R_MEM: begin
                mem_en  = 1'b1;
                state_d = R_DEC;
            end
            R_DEC: begin
                edac_en   = 1'b1;
                edac_read = 1'b1;
                edac_din  = mem_rdata;
                state_d   = R_CHK;
            end
            R_CHK: begin
                dec_fail = (edac_dout == ERROR_CODE);
                state_d  = (dec_fail && can_retry) ? R_MEM : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Nothing may reach the memory or EDAC while reset is held, even mid-transaction.
        if (reset) begin
            edac_en = 1'b0;
            mem_en  = 1'b0;
            mem_we  = 1'b0;
        end
    end

    // Request latch, retry/error counters and the registered response.
    always_ff @(posedge CLK) begin
        if (reset) begin
            addr_q      <= '0;
            wdata_q     <= 8'h0;
            retry_q     <= 2'd0;
            err_cnt_q   <= 16'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                retry_q <= 2'd0;
            end
            if (state_q == W_MEM) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= 8'h0;
            end
            if (state_q == R_CHK) begin
                if (dec_fail) begin
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_q <= err_cnt_q + 16'd1;
                    end
                    if (can_retry) begin
                        retry_q <= retry_q + 2'd1;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 8'h0;
                    end
                end else begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= edac_dout[7:0];
                end
            end
        end
    end

endmodule

// File: doc/edac_mem_seq.md
Name: edac_mem_seq

Overview:
- Request sequencer that sits between the CPU-side byte port and the dual-nibble EDAC wrapper plus its 32-bit protected memory.
- On writes it drives the EDAC in encode mode and stores the 32-bit codeword pair.
- On reads it fetches the codeword, drives the EDAC in decode mode and checks the result against the error code, retrying before reporting failure.
- It also keeps a saturating count of decode failures.

Parameters:
- ADDR_W, 10: memory word-address width.
- ERROR_CODE, 32'hFFFFFFFF: EDAC uncorrectable-error output value; must match the EDAC wrapper setting.
- MAX_RETRY, 1: extra read+decode attempts after a failed decode (0..3).

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  8  write byte.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read byte; 8'h00 on write or on error.
- rsp_err  out  1  read failed after all retries.
- err_count  out  16  saturating count of failed decode attempts.
- edac_en  out  1  EDAC enable.
- edac_read  out  1  EDAC mode, 1 = decode.
- edac_din  out  32  EDAC data in.
- edac_dout  in  32  EDAC registered output, valid the cycle after edac_en=1.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  synchronous read data, valid the cycle after mem_en=1 with mem_we=0.

Behaviour:
- Clocking and reset: one clock, CLK; reset is synchronous and active-high.
- Reset values: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_count=0, retry counter=0, latched address/data=0.
  - While reset is high: req_ready=0, and edac_en, mem_en and mem_we are all 0.
- Reset mid-operation: abort, no rsp_valid, no memory write issued after the reset edge.
- States: IDLE, W_ENC, W_MEM, R_MEM, R_DEC, R_CHK. All memory/EDAC controls are decoded from the registered state; no combinational path from req_* to them.
- Acceptance:
  - req_ready = (state==IDLE) && !reset.
  - On req_valid&&req_ready, latch addr/wdata/we.
  - Go to W_ENC if req_we=1, else R_MEM; clear the retry counter.
- W_ENC: edac_en=1, edac_read=0, edac_din={24'b0,wdata}. Next state W_MEM.
- W_MEM:
  - mem_en=1, mem_we=1, mem_addr=addr, mem_wdata=edac_dout.
  - Next state IDLE; register rsp_valid=1, rsp_err=0, rsp_rdata=0.
- R_MEM: mem_en=1, mem_we=0. Next state R_DEC.
- R_DEC: edac_en=1, edac_read=1, edac_din=mem_rdata. Next state R_CHK.
- R_CHK: edac_en=0; examine edac_dout.
  - If edac_dout==ERROR_CODE:
    - err_count increments, saturating at 16'hFFFF.
    - If retry<MAX_RETRY: retry++, go to R_MEM.
    - Otherwise go to IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=8'h00.
  - Else: go to IDLE with rsp_valid=1, rsp_err=0, rsp_rdata=edac_dout[7:0].
- Latency, counted from the accept edge:
  - write: rsp_valid 3 cycles later;
  - clean read: 4 cycles;
  - each retry adds 3 cycles.
- rsp_valid is high exactly one cycle. A new request may be accepted in that same cycle, since the state is already IDLE.
- Idle outputs: edac_en, mem_en and mem_we are 0 except in the states listed; edac_din and mem_wdata are don't-care when their enable is low.
- Addresses: mem_addr holds the latched address for the whole transaction.
- Wrap-around: retry and error counters never wrap.

Test Plan:
- Reset then idle 5 cycles -> req_ready=1, rsp_valid=0, err_count=0, all enables 0.
- Write addr 0x005 byte 0xA5 with an EDAC model -> edac_en/edac_read=0 with edac_din=0x000000A5 one cycle after accept; mem_we=1 at 0x005 with the model codeword the next cycle; rsp_valid at accept+3, rsp_err=0.
- Read 0x005 back -> mem_en with mem_we=0, then edac_read=1 with edac_din=the stored codeword; rsp_valid at accept+4, rsp_rdata=0xA5, rsp_err=0.
- Force edac_dout=0xFFFFFFFF on the first decode only, MAX_RETRY=1 -> second memory read issued, rsp at accept+7 with rdata=0xA5, err=0, err_count=1.
- Force a persistent error -> rsp at accept+7 with rsp_err=1, rdata=0x00, err_count=2; preload err_count to 0xFFFF -> remains 0xFFFF.
- Two tests on sequencing:
  - Assert reset during R_DEC -> no rsp_valid, state IDLE.
  - Hold req_valid across a rsp_valid cycle -> the next request is accepted in that cycle.
